// File: rtl/branch_predict_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : branch_predict_ctrl_if
//  Brief    : Front-end prediction / redirect bundle between the pipeline and
//             the branch prediction controller.
//  Revision : 1.0 - initial release
// ============================================================================
interface branch_predict_ctrl_if;
    logic        fetch_valid;
    logic [31:0] fetch_PC;
    logic        predict;
    logic        pre_branch;
    logic [31:0] pre_PC;
    logic        ex_valid;
    logic        ex_cond;
    logic [31:0] ex_PC;
    logic        ex_taken;
    logic        ex_mispredict;
    logic [31:0] ex_target;
    logic        redirect_valid;
    logic [31:0] redirect_PC;
    logic        redirect_ready;
    logic        flush_front;

    // master: the prediction controller; slave: the surrounding pipeline.
    modport master (
        input  fetch_valid, fetch_PC, pre_branch, pre_PC,
        input  ex_valid, ex_cond, ex_PC, ex_taken, ex_mispredict, ex_target,
        input  redirect_ready,
        output predict, redirect_valid, redirect_PC, flush_front
    );

    modport slave (
        output fetch_valid, fetch_PC, pre_branch, pre_PC,
        output ex_valid, ex_cond, ex_PC, ex_taken, ex_mispredict, ex_target,
        output redirect_ready,
        input  predict, redirect_valid, redirect_PC, flush_front
    );
endinterface
`default_nettype wire

// File: rtl/branch_predict_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : branch_predict_ctrl
//  Brief    : 2-bit-counter BHT direction predictor plus redirect arbiter for
//             pre-decode and EX mispredict redirects. Optional BHT storage is
//             enabled by defining BPU_BHT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module branch_predict_ctrl #(
    parameter int unsigned BHT_IDX_W = 6,
    parameter logic [1:0]  CNT_INIT  = 2'b01
) (
    input  logic                  clk,
    input  logic                  rst,
    branch_predict_ctrl_if.master bp
);

    localparam logic [1:0] c_IDLE     = 2'b00;
    localparam logic [1:0] c_PEND_PRE = 2'b01;
    localparam logic [1:0] c_PEND_EX  = 2'b10;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [31:0] r_redirect_pc;
    logic [31:0] w_redirect_pc_nxt;
    logic        r_flush;
    logic        w_flush_nxt;
    logic        w_ex_mis;

    assign w_ex_mis = bp.ex_valid & bp.ex_mispredict;

    // EX mispredicts always win; a pre-decode redirect seen while the
    // front end is being flushed belongs to the wrong path and is dropped.
    always_comb begin
        w_state_nxt       = r_state;
        w_redirect_pc_nxt = r_redirect_pc;
        w_flush_nxt       = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (w_ex_mis) begin
                    w_state_nxt       = c_PEND_EX;
                    w_redirect_pc_nxt = bp.ex_target;
                end else if (bp.pre_branch && !r_flush) begin
                    w_state_nxt       = c_PEND_PRE;
                    w_redirect_pc_nxt = bp.pre_PC;
                end
            end
            c_PEND_PRE: begin
                if (w_ex_mis) begin
                    w_state_nxt       = c_PEND_EX;
                    w_redirect_pc_nxt = bp.ex_target;
                end else if (bp.redirect_ready) begin
                    w_state_nxt = c_IDLE;
                end
            end
            c_PEND_EX: begin
                if (w_ex_mis) begin
                    w_redirect_pc_nxt = bp.ex_target;
                end else if (bp.redirect_ready) begin
                    w_state_nxt = c_IDLE;
                    w_flush_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= c_IDLE;
            r_redirect_pc <= 32'h0;
            r_flush       <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_redirect_pc <= w_redirect_pc_nxt;
            r_flush       <= w_flush_nxt;
        end
    end

    // Decoded straight from state so an asynchronous reset drops it at once.
    assign bp.redirect_valid = (r_state == c_PEND_PRE) || (r_state == c_PEND_EX);
    assign bp.redirect_PC    = r_redirect_pc;
    assign bp.flush_front    = r_flush;

`ifdef BPU_BHT_EN
    localparam int unsigned c_BHT_DEPTH = 1 << BHT_IDX_W;

    logic [BHT_IDX_W-1:0]   w_fetch_idx;
    logic [BHT_IDX_W-1:0]   w_ex_idx;
    logic                   w_upd_en;
    logic [c_BHT_DEPTH-1:0] w_cnt_msb;
    logic                   r_predict;
    logic                   w_unused_pc;

    assign w_fetch_idx = bp.fetch_PC[BHT_IDX_W+1:2];
    assign w_ex_idx    = bp.ex_PC[BHT_IDX_W+1:2];
    assign w_upd_en    = bp.ex_valid & bp.ex_cond;
    assign w_unused_pc = ^{bp.fetch_PC[31:BHT_IDX_W+2], bp.fetch_PC[1:0],
                           bp.ex_PC[31:BHT_IDX_W+2], bp.ex_PC[1:0]};

    for (genvar gi = 0; gi < c_BHT_DEPTH; gi++) begin : g_bht_entry
        logic [1:0] r_cnt;
        logic       w_hit;

        assign w_hit = w_upd_en && (w_ex_idx == BHT_IDX_W'(gi));

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_cnt <= CNT_INIT;
            end else if (w_hit) begin
                if (bp.ex_taken && (r_cnt != 2'b11)) begin
                    r_cnt <= r_cnt + 2'b01;
                end else if (!bp.ex_taken && (r_cnt != 2'b00)) begin
                    r_cnt <= r_cnt - 2'b01;
                end
            end
        end

        // Only the direction bit is ever looked up.
        assign w_cnt_msb[gi] = r_cnt[1];
    end

    // Reads the registered counters, so a same-cycle update is not visible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_predict <= 1'b0;
        end else if (bp.fetch_valid) begin
            r_predict <= w_cnt_msb[w_fetch_idx];
        end
    end

    assign bp.predict = r_predict;
`else
    logic w_unused_bht;

    assign w_unused_bht = ^{bp.fetch_valid, bp.fetch_PC, bp.ex_cond, bp.ex_PC,
                            bp.ex_taken, CNT_INIT, 32'(BHT_IDX_W)};
    assign bp.predict   = 1'b0;
`endif

endmodule
`default_nettype wire
